mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255: max cycles to wait for a unit result before abort.
REQ-002 SHALL have ports: clk  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have ports: mdu_in_valid  in  1  CPU request strobe; mdu_op  in  3  RV32M funct3; rs1, rs2  in  32 each  operands.
REQ-005 SHALL have ports: cpu_busy  in  1  CPU cannot accept a result this cycle.
REQ-006 SHALL have ports: mdu_out  out  32  result; mdu_out_valid  out  1; mdu_err  out  1  timeout flag; mdu_busy  out  1.
REQ-007 SHALL have ports to divider: div_in_valid  out  1; div_type  out  2 (op[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU); dividend, divisor  out  32 each; div_out  in  32; div_out_valid  in  1; div_busy  in  1.
REQ-008 SHALL have ports to multiplier: mul_in_valid  out  1; mul_type  out  2 (00 MUL, 01 MULH, 10 MULHSU, 11 MULHU); mul_a, mul_b  out  32 each; mul_out  in  32; mul_out_valid  in  1.

Function
REQ-009 SHALL implement states IDLE, ISSUE, WAIT, HOLD.
REQ-010 In IDLE, mdu_in_valid=1 SHALL capture mdu_op, rs1, rs2 and go to ISSUE, or go directly to HOLD if special case (REQ-014/015).
REQ-011 ISSUE: op[2]=0 -> assert mul_in_valid one cycle, go WAIT; op[2]=1 -> hold in ISSUE while div_busy=1, then assert div_in_valid one cycle, go WAIT.
REQ-012 dividend/divisor/mul_a/mul_b/*_type SHALL be driven from captured registers, stable from ISSUE until leaving WAIT.
REQ-013 WAIT: the selected unit's *_out_valid SHALL register its *_out into the result register and go to HOLD next edge; the other unit's valid is ignored.
REQ-014 Divide by zero (rs2=0): DIV/DIVU result 0xFFFFFFFF, REM/REMU result rs1; divider not started.
REQ-015 Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV result 0x80000000, REM result 0; divider not started.
REQ-016 Special-case latency: result valid in HOLD one cycle after acceptance.
REQ-017 HOLD: mdu_out_valid=1, mdu_out=result; transfer occurs on cycle with cpu_busy=0, then IDLE next edge; mdu_out stable while cpu_busy=1.
REQ-018 mdu_busy SHALL be 1 in every state except IDLE; mdu_in_valid while busy SHALL be ignored (no capture, no queueing).
REQ-019 A new request SHALL NOT be accepted in the same cycle as a transfer; earliest acceptance is the following IDLE cycle.
REQ-020 Wait counter SHALL clear on entering WAIT and increment each WAIT cycle; reaching WAIT_LIMIT without valid -> HOLD with result 0, mdu_err=1.
REQ-021 mdu_err SHALL be valid only with mdu_out_valid and clear on transfer.
REQ-022 *_out_valid in the same cycle the counter reaches WAIT_LIMIT SHALL win (normal result, mdu_err=0).

Reset
REQ-023 rst=0 SHALL immediately force IDLE, counter 0, result 0, all outputs 0, regardless of state.
REQ-024 Reset mid-operation SHALL abandon the request; a late *_out_valid arriving in IDLE SHALL be ignored.

Structure
REQ-025 Shared package mdu_pkg SHALL hold the mdu_op enum (8 funct3 codes), the state enum, and constants DIV_ZERO_Q=0xFFFFFFFF, INT_MIN=0x80000000.
REQ-026 Special-case detection and result selection SHALL be one combinational sub-module mdu_special_case.
REQ-027 Datapath units SHALL NOT be instantiated inside mdu_ctrl; it connects to them via ports only.

Verification
REQ-028 MUL rs1=7 rs2=6, mul_out_valid 3 cycles after issue -> mdu_out=42, mdu_out_valid one cycle, mdu_err=0.
REQ-029 DIVU rs1=100 rs2=0 -> no div_in_valid, mdu_out=0xFFFFFFFF one cycle after acceptance; REMU same operands -> 100.
REQ-030 DIV rs1=0x80000000 rs2=0xFFFFFFFF -> 0x80000000; REM -> 0; divider never started.
REQ-031 DIV with div_busy=1 for 4 cycles -> div_in_valid only after div_busy falls; cpu_busy=1 for 3 cycles in HOLD -> mdu_out held, single transfer.
REQ-032 WAIT_LIMIT=8, divider silent -> HOLD after 8 WAIT cycles, mdu_out=0, mdu_err=1.
REQ-033 rst=0 during WAIT, then late div_out_valid -> outputs 0, state IDLE, no mdu_out_valid.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types and constants for the RV32M multiply/divide controller.
// Opcodes follow RV32M funct3 encoding.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } mdu_state_e;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/mdu_special_case.sv
// Detects divide-by-zero and signed overflow and supplies the
// architectural result so the divider never has to be started.
module mdu_special_case
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        special,
  output logic [31:0] result
);

  logic div_zero;
  logic ovf;

  assign div_zero = (rs2 == '0);
  assign ovf      = (rs1 == INT_MIN) && (rs2 == '1);

  always_comb begin
    special = 1'b0;
    result  = '0;
    unique case (mdu_op_e'(op))
      OP_DIV: begin
        if (div_zero) begin
          special = 1'b1;
          result  = DIV_ZERO_Q;
        end else if (ovf) begin
          special = 1'b1;
          result  = INT_MIN;
        end
      end
      OP_DIVU: begin
        if (div_zero) begin
          special = 1'b1;
          result  = DIV_ZERO_Q;
        end
      end
      OP_REM: begin
        if (div_zero) begin
          special = 1'b1;
          result  = rs1;
        end else if (ovf) begin
          special = 1'b1;
          result  = '0;
        end
      end
      OP_REMU: begin
        if (div_zero) begin
          special = 1'b1;
          result  = rs1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// RV32M controller: sequences external multiplier/divider units,
// short-circuits special divides and times out silent units.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdu_in_valid,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        cpu_busy,
  output logic [31:0] mdu_out,
  output logic        mdu_out_valid,
  output logic        mdu_err,
  output logic        mdu_busy,
  output logic        div_in_valid,
  output logic [1:0]  div_type,
  output logic [31:0] dividend,
  output logic [31:0] divisor,
  input  logic [31:0] div_out,
  input  logic        div_out_valid,
  input  logic        div_busy,
  output logic        mul_in_valid,
  output logic [1:0]  mul_type,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_out,
  input  logic        mul_out_valid
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  mdu_state_e  state;
  mdu_state_e  next;
  logic [2:0]  op_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [31:0] result;
  logic        err;
  logic [CW-1:0] cnt;

  logic        sc_special;
  logic [31:0] sc_result;
  logic        unit_valid;
  logic [31:0] unit_out;
  logic        timeout;

  mdu_special_case u_sc (
    .op      (mdu_op),
    .rs1     (rs1),
    .rs2     (rs2),
    .special (sc_special),
    .result  (sc_result)
  );

  assign unit_valid = op_q[2] ? div_out_valid : mul_out_valid;
  assign unit_out   = op_q[2] ? div_out : mul_out;
  // Last permitted WAIT cycle; a valid result here still wins.
  assign timeout    = (cnt == CW'(WAIT_LIMIT - 1));

  assign div_type = op_q[1:0];
  assign mul_type = op_q[1:0];
  assign dividend = rs1_q;
  assign divisor  = rs2_q;
  assign mul_a    = rs1_q;
  assign mul_b    = rs2_q;
  assign mdu_out  = (state == S_HOLD) ? result : '0;
  assign mdu_err  = (state == S_HOLD) && err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next;
  end

  always_comb begin
    next          = state;
    mul_in_valid  = 1'b0;
    div_in_valid  = 1'b0;
    mdu_out_valid = 1'b0;
    mdu_busy      = 1'b1;
    unique case (state)
      S_IDLE: begin
        mdu_busy = 1'b0;
        if (mdu_in_valid)
          next = sc_special ? S_HOLD : S_ISSUE;
      end
      S_ISSUE: begin
        if (!op_q[2]) begin
          mul_in_valid = 1'b1;
          next         = S_WAIT;
        end else if (!div_busy) begin
          div_in_valid = 1'b1;
          next         = S_WAIT;
        end
      end
      S_WAIT: begin
        if (unit_valid || timeout) next = S_HOLD;
      end
      S_HOLD: begin
        mdu_out_valid = 1'b1;
        if (!cpu_busy) next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      result <= '0;
      err    <= 1'b0;
      cnt    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (mdu_in_valid) begin
            op_q  <= mdu_op;
            rs1_q <= rs1;
            rs2_q <= rs2;
            err   <= 1'b0;
            if (sc_special) result <= sc_result;
          end
        end
        S_ISSUE: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (unit_valid) begin
            result <= unit_out;
          end else if (timeout) begin
            result <= '0;
            err    <= 1'b1;
          end
        end
        S_HOLD: begin
          if (!cpu_busy) err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with hand-driven unit responses.
// Inputs change and outputs are sampled on the falling edge.
module tb_mdu_ctrl;

  logic        clk = 0;
  logic        rst = 0;
  logic        mdu_in_valid = 0;
  logic [2:0]  mdu_op = 0;
  logic [31:0] rs1 = 0;
  logic [31:0] rs2 = 0;
  logic        cpu_busy = 0;
  logic [31:0] mdu_out;
  logic        mdu_out_valid;
  logic        mdu_err;
  logic        mdu_busy;
  logic        div_in_valid;
  logic [1:0]  div_type;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] div_out = 0;
  logic        div_out_valid = 0;
  logic        div_busy = 0;
  logic        mul_in_valid;
  logic [1:0]  mul_type;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_out = 0;
  logic        mul_out_valid = 0;

  int checks = 0;
  int failures = 0;
  int div_starts = 0;
  int xfers = 0;

  mdu_ctrl #(.WAIT_LIMIT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .mdu_in_valid  (mdu_in_valid),
    .mdu_op        (mdu_op),
    .rs1           (rs1),
    .rs2           (rs2),
    .cpu_busy      (cpu_busy),
    .mdu_out       (mdu_out),
    .mdu_out_valid (mdu_out_valid),
    .mdu_err       (mdu_err),
    .mdu_busy      (mdu_busy),
    .div_in_valid  (div_in_valid),
    .div_type      (div_type),
    .dividend      (dividend),
    .divisor       (divisor),
    .div_out       (div_out),
    .div_out_valid (div_out_valid),
    .div_busy      (div_busy),
    .mul_in_valid  (mul_in_valid),
    .mul_type      (mul_type),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_out       (mul_out),
    .mul_out_valid (mul_out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (div_in_valid) div_starts <= div_starts + 1;
    if (mdu_out_valid && !cpu_busy) xfers <= xfers + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one request for one cycle; returns on the next falling edge.
  task automatic req(input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b);
    mdu_op = op;
    rs1 = a;
    rs2 = b;
    mdu_in_valid = 1;
    @(negedge clk);
    mdu_in_valid = 0;
  endtask

  task automatic special(input string tag,
                         input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] exp);
    req(op, a, b);
    check({tag, "_vld"}, mdu_out_valid, 1);
    check({tag, "_out"}, mdu_out, exp);
    check({tag, "_dinv"}, div_in_valid, 0);
    @(negedge clk);
    check({tag, "_done"}, mdu_out_valid, 0);
  endtask

  int x0;
  int d0;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", mdu_busy, 0);
    check("rst_vld", mdu_out_valid, 0);
    check("rst_out", mdu_out, 0);
    check("rst_err", mdu_err, 0);
    check("rst_mulv", mul_in_valid, 0);
    check("rst_divv", div_in_valid, 0);
    rst = 1;
    @(negedge clk);

    // MUL 7*6, result 3 cycles after issue
    x0 = xfers;
    req(3'b000, 7, 6);
    check("mul_inv", mul_in_valid, 1);
    check("mul_a", mul_a, 7);
    check("mul_b", mul_b, 6);
    check("mul_type", mul_type, 0);
    check("mul_busy", mdu_busy, 1);
    @(negedge clk);
    div_out_valid = 1;
    div_out = 32'hDEAD;
    mdu_in_valid = 1;
    rs1 = 99;
    @(negedge clk);
    div_out_valid = 0;
    mdu_in_valid = 0;
    check("mul_ignore", mdu_out_valid, 0);
    check("mul_a_keep", mul_a, 7);
    @(negedge clk);
    mul_out_valid = 1;
    mul_out = 42;
    @(negedge clk);
    mul_out_valid = 0;
    check("mul_vld", mdu_out_valid, 1);
    check("mul_out", mdu_out, 42);
    check("mul_err", mdu_err, 0);
    @(negedge clk);
    check("mul_one", mdu_out_valid, 0);
    check("mul_idle", mdu_busy, 0);
    check("mul_xfer", xfers - x0, 1);

    // Special cases: divider must never start
    d0 = div_starts;
    special("divu0", 3'b101, 100, 0, 32'hFFFF_FFFF);
    special("remu0", 3'b111, 100, 0, 100);
    special("div0", 3'b100, 5, 0, 32'hFFFF_FFFF);
    special("rem0", 3'b110, 5, 0, 5);
    special("divovf", 3'b100, 32'h8000_0000,
            32'hFFFF_FFFF, 32'h8000_0000);
    special("removf", 3'b110, 32'h8000_0000,
            32'hFFFF_FFFF, 0);
    check("sc_nostart", div_starts - d0, 0);

    // DIV held off by div_busy, then cpu_busy backpressure
    div_busy = 1;
    req(3'b100, 100, 7);
    for (int i = 0; i < 4; i++) begin
      check("dbusy_hold", div_in_valid, 0);
      if (i < 3) @(negedge clk);
    end
    div_busy = 0;
    #1;
    check("dbusy_go", div_in_valid, 1);
    check("dbusy_dvd", dividend, 100);
    check("dbusy_dvs", divisor, 7);
    check("dbusy_type", div_type, 0);
    @(negedge clk);
    check("dbusy_once", div_in_valid, 0);
    div_out_valid = 1;
    div_out = 14;
    cpu_busy = 1;
    x0 = xfers;
    @(negedge clk);
    div_out_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("hold_vld", mdu_out_valid, 1);
      check("hold_out", mdu_out, 14);
      @(negedge clk);
    end
    cpu_busy = 0;
    req(3'b000, 3, 5);
    check("xfer_noacc", mdu_busy, 0);
    check("xfer_once", xfers - x0, 1);
    mdu_in_valid = 1;
    @(negedge clk);
    mdu_in_valid = 0;
    check("next_acc", mul_in_valid, 1);
    check("next_a", mul_a, 3);
    @(negedge clk);
    mul_out_valid = 1;
    mul_out = 15;
    @(negedge clk);
    mul_out_valid = 0;
    check("next_out", mdu_out, 15);
    @(negedge clk);

    // Silent divider times out after 8 WAIT cycles
    req(3'b101, 50, 5);
    check("to_start", div_in_valid, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("to_wait", mdu_out_valid, 0);
    end
    @(negedge clk);
    check("to_vld", mdu_out_valid, 1);
    check("to_out", mdu_out, 0);
    check("to_err", mdu_err, 1);
    @(negedge clk);
    check("to_errclr", mdu_err, 0);
    check("to_vldclr", mdu_out_valid, 0);

    // Valid in the last WAIT cycle beats the timeout
    req(3'b101, 50, 5);
    for (int i = 0; i < 8; i++) @(negedge clk);
    div_out_valid = 1;
    div_out = 32'h1234;
    @(negedge clk);
    div_out_valid = 0;
    check("edge_vld", mdu_out_valid, 1);
    check("edge_out", mdu_out, 32'h1234);
    check("edge_err", mdu_err, 0);
    @(negedge clk);

    // Reset during WAIT, then a late result
    req(3'b100, 9, 3);
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("mrst_busy", mdu_busy, 0);
    check("mrst_dvd", dividend, 0);
    check("mrst_out", mdu_out, 0);
    @(negedge clk);
    rst = 1;
    div_out_valid = 1;
    div_out = 77;
    @(negedge clk);
    div_out_valid = 0;
    check("late_vld", mdu_out_valid, 0);
    check("late_busy", mdu_busy, 0);
    check("late_out", mdu_out, 0);
    @(negedge clk);
    check("late_vld2", mdu_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
